// File: rtl/ioctl_sdram_writer_if.sv
// ioctl_sdram_writer_if: word-write request/acknowledge bus between the ioctl writer and the SDRAM controller.
interface ioctl_sdram_writer_if #(parameter int ADDR_W = 24);
   logic              mem_req;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_din;
   logic [1:0]        mem_be;
   modport master (output mem_req, mem_addr, mem_din, mem_be, input mem_ack);
   modport slave  (input mem_req, mem_addr, mem_din, mem_be, output mem_ack);
endinterface

// File: rtl/ioctl_sdram_writer.sv
// ioctl_sdram_writer: packs the ioctl byte stream into 16-bit SDRAM word writes through a small FIFO.
// Defining IOCTL_SDRAM_WRITER_CHECKSUM_EN adds a 16-bit wrapping byte-sum output.
module ioctl_sdram_writer #(
   parameter int ADDR_W    = 24,
   parameter int FIFO_AW   = 3,
   parameter int BASE_ADDR = 0
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 ioctl_download,
   input  logic                 ioctl_wr,
   input  logic [26:0]          ioctl_addr,
   input  logic [7:0]           ioctl_dout,
   output logic                 clkref_n,
   ioctl_sdram_writer_if.master mem,
   output logic                 busy,
   output logic                 done,
`ifdef IOCTL_SDRAM_WRITER_CHECKSUM_EN
   output logic [26:0]          bytes_written,
   output logic [15:0]          checksum
`else
   output logic [26:0]          bytes_written
`endif
);
   localparam int EW = ADDR_W + 18;
   localparam logic [FIFO_AW:0] ONE = (FIFO_AW+1)'(1);
   // Stall upstream once fewer than two entries are free (one in-flight byte plus one flush).
   localparam logic [FIFO_AW:0] STALL_AT = (FIFO_AW+1)'((1 << FIFO_AW) - 1);
   typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;
   typedef enum logic {MIDLE, MREQ} mstate_t;
   state_t            state_q, state_d;
   mstate_t           mstate_q, mstate_d;
   logic              dl_q, restart_q, restart_d;
   logic              pend_v_q, pend_v_d, hold_v_q, hold_v_d;
   logic [7:0]        pend_dat_q, pend_dat_d, hold_dat_q, hold_dat_d;
   logic [ADDR_W-1:0] pend_adr_q, pend_adr_d, hold_adr_q, hold_adr_d, word;
   logic [EW-1:0]     fifo_q [1 << FIFO_AW];
   logic [EW-1:0]     push_e, pend_e, mem_bus_q, mem_bus_d;
   logic [FIFO_AW:0]  wptr_q, wptr_d, rptr_q, rptr_d, rnext, count_q, count_d;
   logic              accept, push, dl_rise, start;
   logic              mem_req_q, mem_req_d, clkref_n_q, clkref_n_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [26:0]       bytes_q, bytes_d;
   assign count_q = wptr_q - rptr_q;
   always_comb begin
      word = ADDR_W'(BASE_ADDR) + ADDR_W'(ioctl_addr[26:1]);
      accept = ioctl_wr & ioctl_download;
      dl_rise = ioctl_download & ~dl_q;
      pend_e = {pend_adr_q, 8'h00, pend_dat_q, 2'b01};
      pend_v_d = pend_v_q;
      pend_dat_d = pend_dat_q;
      pend_adr_d = pend_adr_q;
      hold_v_d = hold_v_q;
      hold_dat_d = hold_dat_q;
      hold_adr_d = hold_adr_q;
      push = 1'b0;
      push_e = pend_e;
      if (hold_v_q) begin
         push = 1'b1;
         push_e = {hold_adr_q, hold_dat_q, 8'h00, 2'b10};
         hold_v_d = 1'b0;
      end else if (accept && !ioctl_addr[0]) begin
         push = pend_v_q;
         {pend_v_d, pend_dat_d, pend_adr_d} = {1'b1, ioctl_dout, word};
      end else if (accept) begin
         push = 1'b1;
         pend_v_d = 1'b0;
         push_e = !pend_v_q ? {word, ioctl_dout, 8'h00, 2'b10} :
                  pend_adr_q == word ? {word, ioctl_dout, pend_dat_q, 2'b11} : pend_e;
         // An odd byte that cannot pair with the pending even byte waits one cycle in hold.
         {hold_v_d, hold_dat_d, hold_adr_d} = {pend_v_q && pend_adr_q != word, ioctl_dout, word};
      end else if (state_q == FLUSH) begin
         push = pend_v_q;
         pend_v_d = 1'b0;
      end
      wptr_d = push ? wptr_q + ONE : wptr_q;
      rnext = rptr_q + ONE;
      rptr_d = rptr_q;
      mstate_d = mstate_q;
      mem_req_d = mem_req_q;
      mem_bus_d = mem_bus_q;
      if (mstate_q == MIDLE && count_q != 0) begin
         mstate_d = MREQ;
         mem_req_d = 1'b1;
         mem_bus_d = fifo_q[rptr_q[FIFO_AW-1:0]];
      end else if (mstate_q == MREQ && mem.mem_ack) begin
         rptr_d = rnext;
         mstate_d = count_q > 1 ? MREQ : MIDLE;
         mem_req_d = count_q > 1;
         mem_bus_d = fifo_q[rnext[FIFO_AW-1:0]];
      end
      count_d = wptr_d - rptr_d;
      start = 1'b0;
      state_d = state_q;
      restart_d = restart_q;
      if (state_q == IDLE && dl_rise) begin
         state_d = LOAD;
         start = 1'b1;
      end
      if (state_q == LOAD && !ioctl_download) state_d = FLUSH;
      if (state_q == FLUSH && !hold_v_q && !accept) state_d = DRAIN;
      if (state_q == DRAIN && count_q == 0 && !hold_v_q && mstate_q == MIDLE) state_d = DONE;
      if (state_q == FLUSH || state_q == DRAIN) restart_d = restart_q | dl_rise;
      if (state_q == DONE) begin
         state_d = (restart_q | dl_rise) ? LOAD : IDLE;
         start = restart_q | dl_rise;
         restart_d = 1'b0;
      end
      bytes_d = (start ? '0 : bytes_q) + 27'(accept);
      busy_d = state_d != IDLE || count_d != 0 || pend_v_d || hold_v_d;
      done_d = state_d == DONE;
      clkref_n_d = count_d >= STALL_AT;
   end
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
         mstate_q <= MIDLE;
         dl_q <= 1'b0;
         restart_q <= 1'b0;
         pend_v_q <= 1'b0;
         pend_dat_q <= '0;
         pend_adr_q <= '0;
         hold_v_q <= 1'b0;
         hold_dat_q <= '0;
         hold_adr_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         mem_req_q <= 1'b0;
         mem_bus_q <= '0;
         clkref_n_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         bytes_q <= '0;
      end else begin
         state_q <= state_d;
         mstate_q <= mstate_d;
         dl_q <= ioctl_download;
         restart_q <= restart_d;
         pend_v_q <= pend_v_d;
         pend_dat_q <= pend_dat_d;
         pend_adr_q <= pend_adr_d;
         hold_v_q <= hold_v_d;
         hold_dat_q <= hold_dat_d;
         hold_adr_q <= hold_adr_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         mem_req_q <= mem_req_d;
         mem_bus_q <= mem_bus_d;
         clkref_n_q <= clkref_n_d;
         busy_q <= busy_d;
         done_q <= done_d;
         bytes_q <= bytes_d;
         if (push) fifo_q[wptr_q[FIFO_AW-1:0]] <= push_e;
      end
   end
   assign mem.mem_req = mem_req_q;
   assign {mem.mem_addr, mem.mem_din, mem.mem_be} = mem_bus_q;
   assign clkref_n = clkref_n_q;
   assign busy = busy_q;
   assign done = done_q;
   assign bytes_written = bytes_q;
`ifdef IOCTL_SDRAM_WRITER_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;
   always_comb checksum_d = (start ? 16'h0 : checksum_q) + (accept ? {8'h00, ioctl_dout} : 16'h0);
   always_ff @(posedge clk_sys) checksum_q <= reset ? 16'h0 : checksum_d;
   assign checksum = checksum_q;
`endif
endmodule
